// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect controls in, ROM address/data, IF/ID register out.
interface inst_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        misalign_err;

  // Fetch unit side
  modport master (
    input  stall, redirect, redirect_pc, rom_data,
    output rom_addr, if_instr, if_pc, if_pc4, if_valid, misalign_err
  );

  // Pipeline / ROM side
  modport slave (
    output stall, redirect, redirect_pc, rom_data,
    input  rom_addr, if_instr, if_pc, if_pc4, if_valid, misalign_err
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC register, ROM addressing and the IF/ID pipeline
// register, with stall hold, redirect flush and a sticky misaligned-target trap.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_fetch_unit_if.master     bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] ifpc_reg, ifpc_next;
  logic [31:0] ifpc4_reg, ifpc4_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;
  logic [31:0] pc_plus4;

  // Modulo-2^32 increment; the ROM address wraps every 4 KiB as a by-product.
  assign pc_plus4 = pc_reg + 32'd4;

  assign bus.rom_addr     = pc_reg[11:0];
  assign bus.if_instr     = instr_reg;
  assign bus.if_pc        = ifpc_reg;
  assign bus.if_pc4       = ifpc4_reg;
  assign bus.if_valid     = valid_reg;
  assign bus.misalign_err = err_reg;

  // State and pipeline registers, synchronous reset to the boot image base.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'h0;
      ifpc_reg  <= 32'h0;
      ifpc4_reg <= 32'h0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      ifpc_reg  <= ifpc_next;
      ifpc4_reg <= ifpc4_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic: redirect beats stall, a misaligned target traps for good.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    ifpc_next  = ifpc_reg;
    ifpc4_next = ifpc4_reg;
    valid_next = valid_reg;
    err_next   = err_reg;

    unique case (state_reg)
      BOOT: begin
        // One bubble cycle after reset so the ROM sees a settled address.
        instr_next = 32'h0;
        valid_next = 1'b0;
        state_next = RUN;
      end

      RUN: begin
        if (bus.redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
          instr_next = 32'h0;
          valid_next = 1'b0;
          err_next   = 1'b1;
          state_next = ERR;
        end else if (bus.redirect) begin
          // Flush the wrong-path word currently being fetched.
          pc_next    = bus.redirect_pc;
          instr_next = 32'h0;
          valid_next = 1'b0;
        end else if (!bus.stall) begin
          instr_next = bus.rom_data;
          ifpc_next  = pc_reg;
          ifpc4_next = pc_plus4;
          valid_next = 1'b1;
          pc_next    = pc_plus4;
        end
      end

      ERR: begin
        // Frozen until reset; keep emitting NOP bubbles.
        instr_next = 32'h0;
        valid_next = 1'b0;
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus randomized
// stall/redirect traffic compared against a behavioural fetch model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic clk;
  logic rst;
  inst_fetch_unit_if bus ();

  inst_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction ROM, word indexed.
  logic [31:0] rom [0:1023];
  assign bus.rom_data = rom[bus.rom_addr[11:2]];

  int tests = 0;
  int fails = 0;

  // Behavioural model of the fetch stage.
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
  logic        m_valid, m_err;
  bit          m_boot, m_dead;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit rd, input logic [31:0] t);
    if (r) begin
      m_pc = RESET_PC; m_instr = 0; m_ifpc = 0; m_ifpc4 = 0;
      m_valid = 0; m_err = 0; m_boot = 1; m_dead = 0;
    end else if (m_dead || m_boot) begin
      m_instr = 0; m_valid = 0; m_boot = 0;
    end else if (rd && (t % 4 != 0)) begin
      m_instr = 0; m_valid = 0; m_err = 1; m_dead = 1;
    end else if (rd) begin
      m_pc = t; m_instr = 0; m_valid = 0;
    end else if (!s) begin
      m_instr = rom[m_pc[11:2]];
      m_ifpc  = m_pc;
      m_ifpc4 = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rom_addr"}, {20'h0, bus.rom_addr}, {20'h0, m_pc[11:0]});
    check({tag, ".if_instr"}, bus.if_instr, m_instr);
    check({tag, ".if_pc"},    bus.if_pc,    m_ifpc);
    check({tag, ".if_pc4"},   bus.if_pc4,   m_ifpc4);
    check({tag, ".if_valid"}, {31'h0, bus.if_valid},     {31'h0, m_valid});
    check({tag, ".misalign"}, {31'h0, bus.misalign_err}, {31'h0, m_err});
  endtask

  // One clock: drive at negedge, update model, sample 1 ns after posedge.
  task automatic step(input string tag, input bit r, input bit s, input bit rd, input logic [31:0] t);
    rst = r; bus.stall = s; bus.redirect = rd; bus.redirect_pc = t;
    model(r, s, rd, t);
    @(posedge clk);
    #1;
    check_all(tag);
    $display("[TB] %s rst=%0b stall=%0b redir=%0b tgt=%h -> addr=%h instr=%h pc=%h v=%0b err=%0b",
             tag, r, s, rd, t, bus.rom_addr, bus.if_instr, bus.if_pc, bus.if_valid, bus.misalign_err);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tgt;
    int r;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[8] = 32'h27bdfff8;
    rst = 1; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;
    @(negedge clk);

    // Reset and boot
    step("reset", 1, 0, 0, 0);
    step("reset2", 1, 0, 0, 0);
    step("boot", 0, 0, 0, 0);
    check("boot.no_valid", {31'h0, bus.if_valid}, 32'h0);
    step("first", 0, 0, 0, 0);
    check("first.pc", bus.if_pc, 32'h0040_0000);
    check("first.pc4", bus.if_pc4, 32'h0040_0004);
    for (int i = 0; i < 9; i++) step("seq", 0, 0, 0, 0);
    check("seq.addr028", {20'h0, bus.rom_addr}, 32'h028);

    // Stall held three cycles, then capture 0x028
    for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 0);
    step("release", 0, 0, 0, 0);
    check("release.pc", bus.if_pc, 32'h0040_0028);

    // Redirect with simultaneous stall
    step("redir_stall", 0, 1, 1, 32'h0040_0020);
    check("redir.addr", {20'h0, bus.rom_addr}, 32'h020);
    step("redir_fetch", 0, 0, 0, 0);
    check("redir.word", bus.if_instr, 32'h27bdfff8);

    // Back-to-back redirects: only the last target is fetched
    step("b2b1", 0, 0, 1, 32'h0040_0100);
    step("b2b2", 0, 0, 1, 32'h0040_0200);
    step("b2b_fetch", 0, 0, 0, 0);
    check("b2b.pc", bus.if_pc, 32'h0040_0200);

    // Wrap at the top of the address space
    step("wrap_redir", 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap_fetch", 0, 0, 0, 0);
    check("wrap.pc", bus.if_pc, 32'hFFFF_FFFC);
    check("wrap.pc4", bus.if_pc4, 32'h0000_0000);
    check("wrap.addr", {20'h0, bus.rom_addr}, 32'h000);

    // Reset mid-run at 0x00400040: that word must never appear as valid
    step("to40", 0, 0, 1, 32'h0040_0040);
    step("rst_mid", 1, 0, 0, 0);
    step("rst_boot", 0, 0, 0, 0);
    step("rst_first", 0, 0, 0, 0);
    check("rst.first_pc", bus.if_pc, 32'h0040_0000);

    // Randomized traffic with aligned redirect targets
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      tgt = (r >= 97) ? ($urandom & 32'hFFFF_FFFC)
                      : (RESET_PC + ($urandom_range(0, 1023) << 2));
      step("rand", 0, r < 25, r >= 88, tgt);
    end

    // Misaligned redirect traps; further traffic ignored
    step("misalign", 0, 0, 1, 32'h0040_0022);
    check("misalign.flag", {31'h0, bus.misalign_err}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 99);
      step("err_hold", 0, r < 40, r >= 50, RESET_PC + ($urandom_range(0, 255) << 2));
    end
    step("err_rst", 1, 0, 0, 0);
    check("err_rst.flag", {31'h0, bus.misalign_err}, 32'h0);
    check("err_rst.addr", {20'h0, bus.rom_addr}, 32'h000);
    step("err_boot", 0, 0, 0, 0);
    step("err_first", 0, 0, 0, 0);

    // Random misaligned mix after recovery
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      step("rand_mis", 0, r < 20, r >= 85, RESET_PC + $urandom_range(0, 4095));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch stage of the MIPS core. Holds the program counter and drives the 12-bit address of the combinational instruction ROM, which returns a 32-bit word in the same cycle. Registers the returned word into the IF/ID pipeline register that feeds the decode stage. Handles decode-stage stalls, taken branch/jump redirects from later stages, and misaligned redirect targets.

Parameters:
RESET_PC, 32'h00400000, PC value loaded on reset (program text base).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
stall  input  1  hold the PC and the IF/ID register; from the hazard unit.
redirect  input  1  taken branch, jump or JR resolved downstream.
redirect_pc  input  32  target address; valid when redirect=1.
rom_addr  output  12  instruction ROM byte address, equal to pc[11:0].
rom_data  input  32  instruction word returned combinationally by the ROM.
if_instr  output  32  IF/ID: fetched instruction; 32'h00000000 on a bubble.
if_pc  output  32  IF/ID: address of if_instr.
if_pc4  output  32  IF/ID: if_pc + 4.
if_valid  output  1  IF/ID: 1 when if_instr is a real fetched instruction.
misalign_err  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Single clock domain. rst is sampled only at the rising edge of clk; there is no asynchronous path.
- Reset values:
  - pc = RESET_PC, so rom_addr = RESET_PC[11:0] = 12'h000.
  - if_instr = 0, if_pc = 0, if_pc4 = 0, if_valid = 0, misalign_err = 0.
  - state = BOOT.
- rom_addr = pc[11:0], purely combinational from the pc register. Upper pc bits are not forwarded.
- Fetch latency: the word at pc appears on if_instr one clock after pc is presented.
- PC arithmetic: pc + 4 is a 32-bit modulo add, so 32'hFFFFFFFC wraps to 0. rom_addr wraps every 4 KiB as a natural consequence.
- FSM states: BOOT, RUN, ERR.
- BOOT (exactly one cycle after rst deasserts):
  - pc held; IF/ID gets a bubble (if_valid=0, if_instr=0).
  - stall and redirect are ignored.
  - Next state: RUN.
- RUN, evaluated each cycle in this priority order:
  1. redirect=1 with redirect_pc[1:0] != 0:
     - pc held; IF/ID gets a bubble.
     - misalign_err <= 1; next state ERR.
  2. redirect=1 with an aligned target:
     - pc <= redirect_pc; IF/ID gets a bubble, flushing the wrong-path word.
     - redirect wins over a simultaneous stall.
  3. stall=1:
     - pc and all IF/ID outputs hold their values unchanged.
  4. Otherwise:
     - if_instr <= rom_data, if_pc <= pc, if_pc4 <= pc+4, if_valid <= 1.
     - pc <= pc+4.
- ERR:
  - pc frozen; if_valid=0 and if_instr=0 every cycle.
  - misalign_err stays 1; all inputs are ignored.
  - Exit only through rst.
- Bubble definition: if_instr=0 (SLL $0,$0,0, a NOP), if_valid=0. if_pc and if_pc4 hold their previous values.
- rst asserted in any state or mid-stall: the next edge applies the reset values. No fetched word survives.
- Back-to-back redirects: each one reloads pc and inserts a bubble. Only the last redirect target is fetched.

Test Plan:
- Reset then run with stall=0 and redirect=0:
  - cycle 0 (BOOT): rom_addr=12'h000, if_valid=0.
  - next edge: if_instr=ROM[0x000], if_pc=32'h00400000, if_pc4=32'h00400004, if_valid=1.
  - following edges: if_pc steps 0x00400004, 0x00400008, and so on, with matching ROM words.
- Stall held 3 cycles while pc=0x00400028:
  - rom_addr stays 12'h028 and the IF/ID outputs are unchanged.
  - after release, the next edge captures ROM[0x028] with if_pc=0x00400028.
- redirect=1, redirect_pc=0x00400020 in the same cycle as stall=1:
  - next edge: if_valid=0, if_instr=0, rom_addr=12'h020.
  - following edge: if_instr=ROM[0x020] (27bdfff8 in the boot image), if_pc=0x00400020.
- redirect_pc=0x00400022:
  - misalign_err=1, pc frozen, if_valid=0 for 10+ cycles despite further redirects.
  - rst clears the flag and returns pc to 0x00400000.
- Wrap: force pc near the top by redirecting to 0xFFFFFFFC:
  - capture yields if_pc=0xFFFFFFFC, if_pc4=0x00000000.
  - the next rom_addr is 12'h000.
- rst asserted mid-run at pc=0x00400040:
  - next edge: pc=0x00400000, if_valid=0, state BOOT.
  - the word at 0x00400040 is never presented with if_valid=1.
